// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction, ALU function, status, register
// and condition codes used by the execute-stage control.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALUADD = 2'b00,
    ALUSUB = 2'b01,
    ALUAND = 2'b10,
    ALUXOR = 2'b11
  } alu_fn_e;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

endpackage

// File: rtl/execute_stage_ctrl_if.sv
// Bus between the execute-stage control (master) and the shared
// combinational ALU (slave).
interface execute_stage_ctrl_if #(
  parameter int W = 64
) ();
  logic [W-1:0] alu_x;
  logic [W-1:0] alu_y;
  logic [1:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic         alu_zf;
  logic         alu_sf;
  logic         alu_of;

  modport master (
    output alu_x, alu_y, alu_ctrl,
    input  alu_result, alu_zf, alu_sf, alu_of
  );

  modport slave (
    input  alu_x, alu_y, alu_ctrl,
    output alu_result, alu_zf, alu_sf, alu_of
  );
endinterface

// File: rtl/execute_stage_ctrl_cond_eval.sv
// jXX/cmovXX condition evaluation from the {ZF,SF,OF} condition codes.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);
  logic zf, sf, of;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end
endmodule

// File: rtl/execute_stage_ctrl.sv
// Y86-64 execute stage: ALU operand/function selection, CC register,
// condition evaluation and the E/M pipeline register.
module execute_stage_ctrl
  import y86_pkg::*;
#(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [3:0]   m_stat,
  input  logic [3:0]   W_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  execute_stage_ctrl_if.master alu,
  output logic         e_cnd,
  output logic [3:0]   e_dstE,
  output logic [W-1:0] e_valE,
  output logic [2:0]   cc_out,
  output logic [3:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
);
  localparam logic [W-1:0] POS_EIGHT = W'(8);
  localparam logic [W-1:0] NEG_EIGHT = -POS_EIGHT;

  logic [2:0]   cc_d, cc_q;
  logic         set_cc;
  logic [3:0]   m_stat_d, m_stat_q, m_icode_d, m_icode_q;
  logic         m_cnd_d, m_cnd_q;
  logic [W-1:0] m_val_e_d, m_val_e_q, m_val_a_d, m_val_a_q;
  logic [3:0]   m_dst_e_d, m_dst_e_q, m_dst_m_d, m_dst_m_q;

  always_comb begin
    alu.alu_x    = '0;
    alu.alu_y    = '0;
    alu.alu_ctrl = ALUADD;
    case (E_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu.alu_x = E_valB;
      default: ;
    endcase
    case (E_icode)
      IRRMOVQ, IOPQ:            alu.alu_y = E_valA;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alu.alu_y = E_valC;
      ICALL, IPUSHQ:            alu.alu_y = NEG_EIGHT;
      IRET, IPOPQ:              alu.alu_y = POS_EIGHT;
      default: ;
    endcase
    if (E_icode == IOPQ) alu.alu_ctrl = E_ifun[1:0];
  end

  // Conditions use the flags already in CC, never the ones being computed now.
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (E_ifun),
    .cnd  (e_cnd)
  );

  assign set_cc = (E_icode == IOPQ) && (m_stat == SAOK) && (W_stat == SAOK) && !M_stall;
  assign cc_d   = set_cc ? {alu.alu_zf, alu.alu_sf, alu.alu_of} : cc_q;
  assign e_dstE = ((E_icode == IRRMOVQ) && !e_cnd) ? RNONE : E_dstE;
  assign e_valE = alu.alu_result;

  // Stall outranks bubble: a held instruction must not be overwritten.
  always_comb begin
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_val_e_d = m_val_e_q;
    m_val_a_d = m_val_a_q;
    m_dst_e_d = m_dst_e_q;
    m_dst_m_d = m_dst_m_q;
    if (!M_stall) begin
      if (M_bubble) begin
        m_stat_d  = SAOK;
        m_icode_d = INOP;
        m_cnd_d   = 1'b0;
        m_val_e_d = '0;
        m_val_a_d = '0;
        m_dst_e_d = RNONE;
        m_dst_m_d = RNONE;
      end else begin
        m_stat_d  = E_stat;
        m_icode_d = E_icode;
        m_cnd_d   = e_cnd;
        m_val_e_d = alu.alu_result;
        m_val_a_d = E_valA;
        m_dst_e_d = e_dstE;
        m_dst_m_d = E_dstM;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q      <= CC_RST;
      m_stat_q  <= SAOK;
      m_icode_q <= INOP;
      m_cnd_q   <= 1'b0;
      m_val_e_q <= '0;
      m_val_a_q <= '0;
      m_dst_e_q <= RNONE;
      m_dst_m_q <= RNONE;
    end else begin
      cc_q      <= cc_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_val_e_q <= m_val_e_d;
      m_val_a_q <= m_val_a_d;
      m_dst_e_q <= m_dst_e_d;
      m_dst_m_q <= m_dst_m_d;
    end
  end

  assign cc_out  = cc_q;
  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_cnd   = m_cnd_q;
  assign M_valE  = m_val_e_q;
  assign M_valA  = m_val_a_q;
  assign M_dstE  = m_dst_e_q;
  assign M_dstM  = m_dst_m_q;
endmodule

// File: tb/tb_execute_stage_ctrl.sv
// Directed bench for execute_stage_ctrl; the bench also plays the ALU.
module tb_execute_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        M_stall, M_bubble;
  logic        e_cnd;
  logic [3:0]  e_dstE;
  logic [63:0] e_valE;
  logic [2:0]  cc_out;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA;

  int errors = 0;
  int checks = 0;

  execute_stage_ctrl_if #(.W(64)) alu_bus ();

  execute_stage_ctrl #(.W(64), .CC_RST(3'b100)) dut (
    .clk(clk), .rst(rst),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .alu(alu_bus),
    .e_cnd(e_cnd), .e_dstE(e_dstE), .e_valE(e_valE), .cc_out(cc_out),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  // Reference ALU: x op y with Y86 flag rules.
  logic [63:0] ax, ay, ar;
  always_comb begin
    ax = alu_bus.alu_x;
    ay = alu_bus.alu_y;
    ar = '0;
    alu_bus.alu_of = 1'b0;
    case (alu_bus.alu_ctrl)
      2'b00: begin ar = ax + ay; alu_bus.alu_of = (ax[63] == ay[63]) && (ar[63] != ax[63]); end
      2'b01: begin ar = ax - ay; alu_bus.alu_of = (ax[63] != ay[63]) && (ar[63] != ax[63]); end
      2'b10: ar = ax & ay;
      default: ar = ax ^ ay;
    endcase
    alu_bus.alu_result = ar;
    alu_bus.alu_zf     = (ar == 64'd0);
    alu_bus.alu_sf     = ar[63];
  end

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] vc, input logic [3:0] de, input logic [3:0] dm);
    E_stat = 4'h1; E_icode = icode; E_ifun = ifun;
    E_valA = va; E_valB = vb; E_valC = vc; E_dstE = de; E_dstM = dm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; M_stall = 0; M_bubble = 0; m_stat = 4'h1; W_stat = 4'h1;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #12;
    chk("reset cc_out", 64'(cc_out), 64'h4);
    chk("reset M_stat", 64'(M_stat), 64'h1);
    chk("reset M_icode", 64'(M_icode), 64'h1);
    chk("reset M_dstE", 64'(M_dstE), 64'hF);
    chk("reset M_dstM", 64'(M_dstM), 64'hF);
    chk("reset M_valE", M_valE, 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overflow();
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF);
    #1;
    chk("add alu_ctrl", 64'(alu_bus.alu_ctrl), 64'h0);
    chk("add alu_x", alu_bus.alu_x, 64'h7FFF_FFFF_FFFF_FFFF);
    step();
    chk("ovf M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("ovf cc_out", 64'(cc_out), 64'h3);
    chk("ovf M_icode", 64'(M_icode), 64'h6);
    chk("ovf M_dstE", 64'(M_dstE), 64'h2);
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    #1 chk("ovf jl", 64'(e_cnd), 64'h0);
    E_ifun = 4'h6;
    #1 chk("ovf jg", 64'(e_cnd), 64'h1);
  endtask

  task automatic test_sub_equal();
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1, 4'hF);
    #1;
    chk("sub alu_ctrl", 64'(alu_bus.alu_ctrl), 64'h1);
    chk("sub cc before edge", 64'(cc_out), 64'h3);
    step();
    chk("sub cc_out", 64'(cc_out), 64'h4);
    chk("sub M_valE", M_valE, 64'h0);
    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    #1 chk("sub je", 64'(e_cnd), 64'h1);
    E_ifun = 4'h4;
    #1 chk("sub jne", 64'(e_cnd), 64'h0);
  endtask

  task automatic test_cmov();
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h1, 4'hF);
    step();
    chk("cmov prep cc", 64'(cc_out), 64'h0);
    drive(4'h2, 4'h1, 64'h55, 64'h99, 64'd0, 4'h3, 4'hF);
    #1;
    chk("cmovle cc000 e_cnd", 64'(e_cnd), 64'h0);
    chk("cmovle cc000 e_dstE", 64'(e_dstE), 64'hF);
    chk("cmov alu_x", alu_bus.alu_x, 64'h0);
    chk("cmov e_valE", e_valE, 64'h55);
    step();
    chk("cmovle cc000 M_dstE", 64'(M_dstE), 64'hF);
    chk("cmovle cc000 M_cnd", 64'(M_cnd), 64'h0);
    chk("cmov M_valE", M_valE, 64'h55);
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1, 4'hF);
    step();
    drive(4'h2, 4'h1, 64'h55, 64'h99, 64'd0, 4'h3, 4'hF);
    step();
    chk("cmovle cc100 M_dstE", 64'(M_dstE), 64'h3);
    chk("cmovle cc100 M_cnd", 64'(M_cnd), 64'h1);
    chk("cmov keeps cc", 64'(cc_out), 64'h4);
  endtask

  task automatic test_cc_suppress();
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h1, 4'hF);
    m_stat = 4'h3;
    step();
    chk("cc hold m_stat ADR", 64'(cc_out), 64'h4);
    m_stat = 4'h1; W_stat = 4'h2;
    step();
    chk("cc hold W_stat HLT", 64'(cc_out), 64'h4);
    W_stat = 4'h1; M_stall = 1'b1;
    step();
    chk("cc hold M_stall", 64'(cc_out), 64'h4);
    M_stall = 1'b0;
    step();
    chk("cc update resumes", 64'(cc_out), 64'h0);
    chk("suppress M_valE", M_valE, 64'h2);
  endtask

  task automatic test_stall_bubble();
    drive(4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF);
    M_stall = 1'b1; M_bubble = 1'b1;
    step();
    chk("stall+bubble M_icode", 64'(M_icode), 64'h6);
    chk("stall+bubble M_valE", M_valE, 64'h2);
    M_stall = 1'b0;
    step();
    chk("bubble M_icode", 64'(M_icode), 64'h1);
    chk("bubble M_stat", 64'(M_stat), 64'h1);
    chk("bubble M_dstE", 64'(M_dstE), 64'hF);
    chk("bubble M_valE", M_valE, 64'h0);
    chk("bubble M_cnd", 64'(M_cnd), 64'h0);
    M_bubble = 1'b0;
    #1;
    chk("push alu_y", alu_bus.alu_y, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("push alu_ctrl", 64'(alu_bus.alu_ctrl), 64'h0);
    step();
    chk("push M_valE", M_valE, 64'hF8);
    chk("push M_valA", M_valA, 64'h77);
    chk("push M_icode", 64'(M_icode), 64'hA);
    chk("push M_dstE", 64'(M_dstE), 64'h4);
  endtask

  task automatic test_misc_operands();
    drive(4'hB, 4'h0, 64'd0, 64'h200, 64'd0, 4'h4, 4'h3);
    #1 chk("popq alu_y", alu_bus.alu_y, 64'h8);
    chk("popq e_valE", e_valE, 64'h208);
    drive(4'h3, 4'h0, 64'h11, 64'h22, 64'h1234, 4'h5, 4'hF);
    #1 chk("irmovq alu_x", alu_bus.alu_x, 64'h0);
    chk("irmovq e_valE", e_valE, 64'h1234);
    drive(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("ifun7 e_cnd", 64'(e_cnd), 64'h0);
    E_ifun = 4'h0;
    #1 chk("jmp e_cnd", 64'(e_cnd), 64'h1);
  endtask

  task automatic test_async_reset();
    drive(4'h6, 4'h2, 64'h0F, 64'hF0, 64'd0, 4'h1, 4'hF);
    step();
    chk("pre-reset cc", 64'(cc_out), 64'h4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst cc", 64'(cc_out), 64'h4);
    chk("async rst M_icode", 64'(M_icode), 64'h1);
    chk("async rst M_valE", M_valE, 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_sub_equal();
    test_cmov();
    test_cc_suppress();
    test_stall_bubble();
    test_misc_operands();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
